// File: rtl/sincos_arb_pkg.sv
// Shared types and helpers for the sincos round-robin front end.
package sincos_arb_pkg;

    // Largest supported requester count and the id width that covers it.
    localparam int MAX_NREQ = 16;
    localparam int MAX_IDW  = 4;

    // Requester phase width: two quadrant bits above the core angle.
    function automatic int pw_of(input int aw);
        return aw + 2;
    endfunction

    // Requester id width, never narrower than one bit.
    function automatic int idw_of(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    // One stage of the in-flight tracking pipeline.
    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    // Find the first set bit of req, searching upward from ptr and wrapping
    // modulo n. Returns {found, index}.
    function automatic logic [MAX_IDW:0] rotate_first_one(
        input logic [MAX_NREQ-1:0] req,
        input logic [MAX_IDW-1:0]  ptr,
        input int                  n
    );
        logic               found;
        logic [MAX_IDW-1:0] idx;
        int                 j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!found && req[j]) begin
                    found = 1'b1;
                    idx   = j[MAX_IDW-1:0];
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/sincos_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant plus rotating priority pointer.
module rr_arbiter
    import sincos_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  id_o,
    output logic            accept_o
);

    logic [IDW-1:0]      ptr_reg;
    logic [IDW-1:0]      ptr_next;
    logic [MAX_NREQ-1:0] req_ext;
    logic [MAX_IDW:0]    pick;
    logic [MAX_IDW-1:0]  pick_id;
    logic                accept;

    // Search from the pointer; nothing is granted while reset is held.
    always_comb begin
        req_ext  = MAX_NREQ'(req_i);
        pick     = rotate_first_one(req_ext, MAX_IDW'(ptr_reg), NREQ);
        pick_id  = pick[MAX_IDW-1:0];
        accept   = pick[MAX_IDW] & ~rst_i;
        ptr_next = ptr_reg;
        if (accept) begin
            if (pick_id == MAX_IDW'(NREQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = pick_id[IDW-1:0] + IDW'(1);
            end
        end
    end

    // Decode the chosen index into a one-hot grant.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant_o[gi] = accept && (pick_id == MAX_IDW'(gi));
    end

    assign id_o     = pick_id[IDW-1:0];
    assign accept_o = accept;

    // Pointer moves just past the last winner; holds when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/sincos_arbiter.sv
// Shares one pipelined sincos core between NREQ requesters and returns
// each result tagged with the requester that issued it.
module sincos_arbiter
    import sincos_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 16,
    parameter int AW       = 14,
    parameter int CORE_LAT = 17,
    localparam int PW      = pw_of(AW),
    localparam int IDW     = idw_of(NREQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NREQ-1:0]  req_valid_i,
    input  logic [NREQ*PW-1:0] req_phase_i,
    output logic [NREQ-1:0]  req_ready_o,
    output logic [1:0]       core_quadrant_o,
    output logic [AW-1:0]    core_angle_o,
    input  logic [DW-1:0]    core_sin_i,
    input  logic [DW-1:0]    core_cos_i,
    output logic             res_valid_o,
    output logic [IDW-1:0]   res_id_o,
    output logic [DW-1:0]    res_sin_o,
    output logic [DW-1:0]    res_cos_o
);

    logic [IDW-1:0] grant_id;
    logic           accept;
    logic [PW-1:0]  phase_arr [NREQ];
    logic [PW-1:0]  phase_sel;
    tag_t           tag_reg   [CORE_LAT];
    tag_t           tag_last;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_valid_i),
        .grant_o  (req_ready_o),
        .id_o     (grant_id),
        .accept_o (accept)
    );

    // Unpack the flat phase bus into one word per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_phase
        assign phase_arr[gi] = req_phase_i[gi*PW +: PW];
    end

    assign phase_sel = phase_arr[grant_id];
    assign tag_last  = tag_reg[CORE_LAT-1];

    // Issue register: only updates on acceptance so the core sees no toggling when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            core_quadrant_o <= '0;
            core_angle_o    <= '0;
        end else if (accept) begin
            core_quadrant_o <= phase_sel[PW-1:AW];
            core_angle_o    <= phase_sel[AW-1:0];
        end
    end

    // Tag shift register mirrors the core latency; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < CORE_LAT; k++) begin
                tag_reg[k] <= '0;
            end
        end else begin
            tag_reg[0].valid <= accept;
            tag_reg[0].id    <= MAX_IDW'(grant_id);
            for (int k = 1; k < CORE_LAT; k++) begin
                tag_reg[k] <= tag_reg[k-1];
            end
        end
    end

    // Output register captures the core result when its tag emerges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_o <= 1'b0;
            res_id_o    <= '0;
            res_sin_o   <= '0;
            res_cos_o   <= '0;
        end else if (tag_last.valid) begin
            res_valid_o <= 1'b1;
            res_id_o    <= tag_last.id[IDW-1:0];
            res_sin_o   <= core_sin_i;
            res_cos_o   <= core_cos_i;
        end else begin
            res_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sincos_arbiter.sv
// Directed bench for sincos_arbiter with a stand-in core whose outputs are
// sin = {quadrant, angle} and cos = ~sin, delayed to match the core latency.
module tb_sincos_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 16;
    localparam int AW       = 14;
    localparam int PW       = AW + 2;
    localparam int CORE_LAT = 17;

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] s;
        logic [15:0] c;
    } exp_t;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [NREQ-1:0]    req_valid_i = '0;
    logic [NREQ*PW-1:0] req_phase_i = '0;
    logic [NREQ-1:0]    req_ready_o;
    logic [1:0]         core_quadrant_o;
    logic [AW-1:0]      core_angle_o;
    logic [DW-1:0]      core_sin_i;
    logic [DW-1:0]      core_cos_i;
    logic               res_valid_o;
    logic [1:0]         res_id_o;
    logic [DW-1:0]      res_sin_o;
    logic [DW-1:0]      res_cos_o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    logic [15:0] core_pipe [CORE_LAT-1];

    sincos_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .CORE_LAT(CORE_LAT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_phase_i(req_phase_i),
        .req_ready_o(req_ready_o),
        .core_quadrant_o(core_quadrant_o), .core_angle_o(core_angle_o),
        .core_sin_i(core_sin_i), .core_cos_i(core_cos_i),
        .res_valid_o(res_valid_o), .res_id_o(res_id_o),
        .res_sin_o(res_sin_o), .res_cos_o(res_cos_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Stand-in core: input change visible at the output CORE_LAT-1 edges later.
    always @(posedge clk_i) begin
        core_pipe[0] <= {core_quadrant_o, core_angle_o};
        for (int k = 1; k < CORE_LAT - 1; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign core_sin_i = core_pipe[CORE_LAT-2];
    assign core_cos_i = ~core_pipe[CORE_LAT-2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Every result pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (res_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 32'(res_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_cycle", 32'(cyc), 32'(e.cyc));
                chk("res_id",    32'(res_id_o), 32'(e.id));
                chk("res_sin",   32'(res_sin_o), 32'(e.s));
                chk("res_cos",   32'(res_cos_o), 32'(e.c));
                $display("result cyc=%0d id=%0d sin=%h cos=%h", cyc, res_id_o, res_sin_o, res_cos_o);
            end
        end
    end

    task automatic set_phase(input int i, input logic [15:0] ph);
        req_phase_i[i*PW +: PW] = ph;
    endtask

    // Check the grant in the current cycle, record the expected result, advance one cycle.
    task automatic grant_step(input logic [3:0] exp_ready, input int id, input logic [15:0] ph);
        exp_t e;
        @(negedge clk_i);
        chk("ready", 32'(req_ready_o), 32'(exp_ready));
        $display("grant cyc=%0d ready=%b", cyc, req_ready_o);
        if (exp_ready != 4'b0000) begin
            e.cyc = cyc + CORE_LAT + 1;
            e.id  = id;
            e.s   = ph;
            e.c   = ~ph;
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk_i);
        end
        #1;
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_quadrant", 32'(core_quadrant_o), 32'd0);
        chk("rst_angle",    32'(core_angle_o), 32'd0);
        chk("rst_res_valid", 32'(res_valid_o), 32'd0);
        chk("rst_res_id",   32'(res_id_o), 32'd0);
        chk("rst_res_sin",  32'(res_sin_o), 32'd0);
        chk("rst_res_cos",  32'(res_cos_o), 32'd0);
    endtask

    initial begin
        // Reset with requester 1 already valid: not granted until reset falls.
        req_valid_i = 4'b0010;
        set_phase(1, 16'h1234);
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outputs();
        grant_step(4'b0000, 0, 16'h0);
        rst_i = 1'b0;
        grant_step(4'b0010, 1, 16'h1234);
        req_valid_i = 4'b0000;
        chk("issue_quadrant_a", 32'(core_quadrant_o), 32'd0);
        chk("issue_angle_a",    32'(core_angle_o), 32'h1234);
        drain();

        // Single request from requester 2, quadrant 1 angle 0.
        req_valid_i = 4'b0100;
        set_phase(2, 16'h4000);
        grant_step(4'b0100, 2, 16'h4000);
        req_valid_i = 4'b0000;
        chk("issue_quadrant_b", 32'(core_quadrant_o), 32'd1);
        chk("issue_angle_b",    32'(core_angle_o), 32'd0);
        drain();

        // Five accepts (pointer at 3), then reset: none of them may return.
        req_valid_i = 4'b1111;
        set_phase(0, 16'h1111);
        set_phase(1, 16'h2222);
        set_phase(2, 16'h3333);
        set_phase(3, 16'h4444);
        grant_step(4'b1000, 3, 16'h4444);
        grant_step(4'b0001, 0, 16'h1111);
        grant_step(4'b0010, 1, 16'h2222);
        grant_step(4'b0100, 2, 16'h3333);
        grant_step(4'b1000, 3, 16'h4444);
        req_valid_i = 4'b0000;
        rst_i = 1'b1;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk_reset_outputs();
        repeat (30) @(posedge clk_i);
        #1;
        chk("post_reset_quiet", 32'(res_valid_o), 32'd0);

        // All four valid for 12 cycles: pointer restarted at 0.
        req_valid_i = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            case (k % 4)
                0: grant_step(4'b0001, 0, 16'h1111);
                1: grant_step(4'b0010, 1, 16'h2222);
                2: grant_step(4'b0100, 2, 16'h3333);
                default: grant_step(4'b1000, 3, 16'h4444);
            endcase
        end
        req_valid_i = 4'b0000;
        drain();

        // Move pointer to 2, then requesters 1 and 3 compete: 3,1,3.
        req_valid_i = 4'b0010;
        grant_step(4'b0010, 1, 16'h2222);
        req_valid_i = 4'b1010;
        grant_step(4'b1000, 3, 16'h4444);
        grant_step(4'b0010, 1, 16'h2222);
        grant_step(4'b1000, 3, 16'h4444);
        req_valid_i = 4'b0000;
        drain();

        // Phase sweep over the whole range from requester 0, one per cycle.
        req_valid_i = 4'b0001;
        for (int k = 0; k <= 32; k++) begin
            logic [15:0] ph;
            ph = (k == 32) ? 16'hFFFF : 16'(k * 16'h0800);
            set_phase(0, ph);
            grant_step(4'b0001, 0, ph);
        end
        req_valid_i = 4'b0000;
        drain();

        // Idle gap: core inputs hold the last issued phase, no results.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            chk("idle_quadrant", 32'(core_quadrant_o), 32'd3);
            chk("idle_angle",    32'(core_angle_o), 32'h3FFF);
            chk("idle_res_valid", 32'(res_valid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 4'b0100;
        set_phase(2, 16'h8001);
        grant_step(4'b0100, 2, 16'h8001);
        req_valid_i = 4'b0000;
        chk("issue_quadrant_c", 32'(core_quadrant_o), 32'd2);
        chk("issue_angle_c",    32'(core_angle_o), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
